// File: rtl/timer_event_scheduler_if.sv
// Avalon-MM slave bus bundle for timer_event_scheduler.
// The CPU side drives the strobes and data, the timer block returns registered readdata.
interface timer_event_scheduler_if;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output write, read, address, writedata, input readdata);
    modport slave  (input write, read, address, writedata, output readdata);
endinterface

// File: rtl/timer_event_scheduler.sv
// CHANNELS periodic timers sharing one prescaled tick, with round-robin GRANT hand-out and a single irq.
// Define TES_OVERRUN_EN to add per-channel overrun flags at address 6.
module timer_event_scheduler #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 100000,
    parameter int PERIOD_W = 16
) (
    input  logic                   csi_clk,
    input  logic                   rsi_reset,
    output logic                   irq,
    timer_event_scheduler_if.slave avs_s0
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam int CH_W = $clog2(CHANNELS);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [2:0] {
        A_PENDING = 3'd0,
        A_CH_SEL  = 3'd1,
        A_PERIOD  = 3'd2,
        A_ENABLE  = 3'd3,
        A_GRANT   = 3'd4,
        A_TICKS   = 3'd5,
        A_OVERRUN = 3'd6
    } addr_e;

    logic [PS_W-1:0]     r_ps;
    logic [31:0]         r_ticks;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_enable;
    logic [PERIOD_W-1:0] r_period [CHANNELS];
    logic [PERIOD_W-1:0] r_cnt    [CHANNELS];
    logic [3:0]          r_ch_sel;
    logic [CH_W-1:0]     r_last;
    logic                r_irq;
    logic [31:0]         r_readdata;

    logic                w_tick;
    logic                w_wr_pending, w_wr_ch_sel, w_wr_period, w_wr_enable, w_rd_grant;
    logic [CHANNELS-1:0] w_per_wr;
    logic [CHANNELS-1:0] w_fire;
    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_clr;
    logic [PERIOD_W-1:0] w_sel_period;
    logic                w_gnt_valid;
    logic [CH_W-1:0]     w_gnt_idx;
    logic [CH_W:0]       w_cand;
    logic                w_grant_hit;
    logic [31:0]         w_overrun_rd;
    logic [31:0]         w_rdata;
    logic                w_unused_wdata;

    assign w_tick       = (r_ps == PS_LAST);
    assign w_wr_pending = avs_s0.write && (avs_s0.address == A_PENDING);
    assign w_wr_ch_sel  = avs_s0.write && (avs_s0.address == A_CH_SEL);
    assign w_wr_period  = avs_s0.write && (avs_s0.address == A_PERIOD);
    assign w_wr_enable  = avs_s0.write && (avs_s0.address == A_ENABLE);
    assign w_rd_grant   = avs_s0.read  && (avs_s0.address == A_GRANT);
    assign w_req        = r_pending & r_enable;
    assign w_grant_hit  = w_rd_grant && w_gnt_valid;
    assign w_unused_wdata = ^avs_s0.writedata;

    // A PERIOD write to a channel suppresses its fire in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_per_wr     = '0;
        w_fire       = '0;
        w_sel_period = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_per_wr[i] = w_wr_period && (r_ch_sel == 4'(i));
            w_fire[i]   = w_tick && r_enable[i] && !w_per_wr[i] && (r_cnt[i] == r_period[i]);
            if (r_ch_sel == 4'(i)) w_sel_period = r_period[i];
        end
    end

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_cand = {1'b0, r_last} + (CH_W+1)'(k + 1);
            if (w_cand >= (CH_W+1)'(CHANNELS)) w_cand = w_cand - (CH_W+1)'(CHANNELS);
            if (!w_gnt_valid && w_req[w_cand[CH_W-1:0]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_cand[CH_W-1:0];
            end
        end
    end

    assign w_clr = (w_wr_pending ? avs_s0.writedata[CHANNELS-1:0] : '0)
                 | (w_grant_hit  ? (CHANNELS'(1) << w_gnt_idx)     : '0);

`ifdef TES_OVERRUN_EN
    logic [CHANNELS-1:0] r_overrun;
    logic                w_wr_overrun;

    assign w_wr_overrun = avs_s0.write && (avs_s0.address == A_OVERRUN);
    assign w_overrun_rd = 32'(r_overrun);

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) r_overrun <= '0;
        else r_overrun <= (r_overrun & ~(w_wr_overrun ? avs_s0.writedata[CHANNELS-1:0] : '0))
                        | (w_fire & r_pending);
    end
`else
    assign w_overrun_rd = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (avs_s0.address)
            A_PENDING: w_rdata = 32'(r_pending);
            A_CH_SEL:  w_rdata = 32'(r_ch_sel);
            A_PERIOD:  w_rdata = 32'(w_sel_period);
            A_ENABLE:  w_rdata = 32'(r_enable);
            A_GRANT:   w_rdata = w_gnt_valid ? {1'b1, 27'b0, 4'(w_gnt_idx)} : '0;
            A_TICKS:   w_rdata = r_ticks;
            A_OVERRUN: w_rdata = w_overrun_rd;
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_ps    <= '0;
            r_ticks <= '0;
        end else begin
            // NOTE: state uses <= so every register here sees pre-edge values of the others.
            if (r_enable == '0 || w_tick) r_ps <= '0;
            else                          r_ps <= r_ps + 1'b1;
            if (w_tick) r_ticks <= r_ticks + 32'd1;
        end
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            // NOTE: the period/count arrays are plain flops and software expects 0 after reset, so they are reset too.
            for (int i = 0; i < CHANNELS; i++) begin
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_per_wr[i]) begin
                    r_period[i] <= avs_s0.writedata[PERIOD_W-1:0];
                    r_cnt[i]    <= '0;
                end else if (!r_enable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_tick) begin
                    r_cnt[i] <= (r_cnt[i] == r_period[i]) ? '0 : r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A fire in the same cycle as a W1C or GRANT clear leaves pending set.
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_ch_sel   <= '0;
            r_last     <= CH_W'(CHANNELS - 1);
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_fire;
            r_irq      <= |w_req;
            r_readdata <= avs_s0.read ? w_rdata : '0;
            if (w_wr_enable) r_enable <= avs_s0.writedata[CHANNELS-1:0];
            if (w_wr_ch_sel && ({1'b0, avs_s0.writedata[3:0]} < 5'(CHANNELS)))
                r_ch_sel <= avs_s0.writedata[3:0];
            if (w_grant_hit) r_last <= w_gnt_idx;
        end
    end

    assign irq             = r_irq;
    assign avs_s0.readdata = r_readdata;
endmodule

// File: tb/tb_timer_event_scheduler.sv
// Self-checking bench for timer_event_scheduler: directed scenarios plus random bus traffic
// compared every cycle against a countdown-based reference model.
module tb_timer_event_scheduler;
    localparam int CH = 4;
    localparam int PS = 4;
    localparam int PW = 16;
`ifdef TES_OVERRUN_EN
    localparam logic [31:0] OVR_EXP = 32'h1;
`else
    localparam logic [31:0] OVR_EXP = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic irq;

    timer_event_scheduler_if bus();

    timer_event_scheduler #(.CHANNELS(CH), .PRESCALE(PS), .PERIOD_W(PW)) dut (
        .csi_clk   (clk),
        .rsi_reset (rst),
        .irq       (irq),
        .avs_s0    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel counts down the ticks left until its next fire.
    logic [CH-1:0] m_pending, m_enable, m_overrun;
    int unsigned   m_period [CH];
    int unsigned   m_left   [CH];
    int unsigned   m_phase, m_ticks, m_chsel, m_last;
    logic          m_irq;
    logic [31:0]   m_rdata;
    logic [31:0]   last_rd;

    task automatic model_reset();
        m_pending = '0; m_enable = '0; m_overrun = '0;
        for (int i = 0; i < CH; i++) begin m_period[i] = 0; m_left[i] = 0; end
        m_phase = 0; m_ticks = 0; m_chsel = 0; m_last = CH - 1;
        m_irq = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step(input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] d);
        bit            tick, gval;
        int unsigned   gidx, c;
        logic [CH-1:0] req, clr, fire;
        logic [31:0]   rdv;
        tick = (m_phase == PS - 1);
        req  = m_pending & m_enable;
        gval = 1'b0; gidx = 0;
        for (int k = 1; k <= CH; k++) begin
            c = (m_last + k) % CH;
            if (!gval && req[c]) begin gval = 1'b1; gidx = c; end
        end
        rdv = '0;
        if (rd) begin
            case (a)
                3'd0: rdv = 32'(m_pending);
                3'd1: rdv = m_chsel;
                3'd2: rdv = m_period[m_chsel];
                3'd3: rdv = 32'(m_enable);
                3'd4: rdv = gval ? (32'h8000_0000 | gidx) : 32'h0;
                3'd5: rdv = m_ticks;
`ifdef TES_OVERRUN_EN
                3'd6: rdv = 32'(m_overrun);
`endif
                default: rdv = '0;
            endcase
        end
        clr = '0;
        if (wr && a == 3'd0) clr = d[CH-1:0];
        if (rd && a == 3'd4 && gval) begin clr[gidx] = 1'b1; m_last = gidx; end
        fire = '0;
        for (int i = 0; i < CH; i++) begin
            if (wr && a == 3'd2 && m_chsel == i) begin
                m_period[i] = 32'(d[PW-1:0]);
                m_left[i]   = m_period[i];
            end else if (!m_enable[i]) begin
                m_left[i] = m_period[i];
            end else if (tick) begin
                if (m_left[i] == 0) begin fire[i] = 1'b1; m_left[i] = m_period[i]; end
                else m_left[i] = m_left[i] - 1;
            end
        end
        m_overrun = (m_overrun & ~((wr && a == 3'd6) ? d[CH-1:0] : '0)) | (fire & m_pending);
        m_irq     = |req;
        m_pending = (m_pending & ~clr) | fire;
        m_phase   = (m_enable == '0) ? 0 : (m_phase + 1) % PS;
        if (tick) m_ticks = m_ticks + 1;
        if (wr && a == 3'd3) m_enable = d[CH-1:0];
        if (wr && a == 3'd1 && d[3:0] < CH) m_chsel = 32'(d[3:0]);
        m_rdata = rdv;
    endtask

    // One bus cycle: drive at the falling edge, sample at the next falling edge.
    task automatic cycle(input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] d);
        bus.write = wr; bus.read = rd; bus.address = a; bus.writedata = d;
        @(posedge clk);
        model_step(wr, rd, a, d);
        @(negedge clk);
        bus.write = 1'b0; bus.read = 1'b0;
        last_rd = bus.readdata;
        check("readdata", bus.readdata, m_rdata);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d); cycle(1'b1, 1'b0, a, d); endtask
    task automatic rd_reg(input logic [2:0] a);                      cycle(1'b0, 1'b1, a, 32'h0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset release: every register reads 0 and GRANT has nothing to hand out.
        for (int a = 0; a < 6; a++) begin
            rd_reg(3'(a));
            check("t1_reg_zero", last_rd, 32'h0);
        end
        rd_reg(3'd4);
        check("t1_grant_empty", last_rd, 32'h0);

        // Period firing: channel 1, period 2 -> fires on the third tick.
        apply_reset();
        wr_reg(3'd1, 32'd1);
        wr_reg(3'd2, 32'd2);
        wr_reg(3'd3, 32'h2);
        idle(11);
        rd_reg(3'd0);
        check("t2_pend_before", last_rd, 32'h0);
        check("t2_irq_before", 32'(irq), 32'h0);
        rd_reg(3'd0);
        check("t2_pend_set", last_rd, 32'h2);
        check("t2_irq_set", 32'(irq), 32'h1);
        rd_reg(3'd5);
        check("t2_ticks", last_rd, 32'd3);

        // Round-robin: channels 0, 2, 3 pending together, last = 3 after reset.
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            if (c != 1) begin
                wr_reg(3'd1, 32'(c));
                wr_reg(3'd2, 32'd10);
            end
        end
        wr_reg(3'd3, 32'hD);
        idle(50);
        rd_reg(3'd4);
        check("t3_grant0", last_rd, 32'h8000_0000);
        rd_reg(3'd4);
        check("t3_grant2", last_rd, 32'h8000_0002);
        rd_reg(3'd4);
        check("t3_grant3", last_rd, 32'h8000_0003);
        check("t3_irq_still", 32'(irq), 32'h1);
        rd_reg(3'd4);
        check("t3_grant_none", last_rd, 32'h0);
        check("t3_irq_drop", 32'(irq), 32'h0);

        // Set-wins: W1C of bit 0 lands on a tick where channel 0 (period 0) fires.
        apply_reset();
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd3, 32'h1);
        idle(7);
        wr_reg(3'd0, 32'h1);
        rd_reg(3'd0);
        check("t4_set_wins", last_rd, 32'h1);
        wr_reg(3'd0, 32'h1);
        rd_reg(3'd0);
        check("t4_w1c_clears", last_rd, 32'h0);

        // Disable mid-count: the count restarts, so the next fire is 6 ticks after re-enable.
        apply_reset();
        wr_reg(3'd2, 32'd5);
        wr_reg(3'd3, 32'h1);
        idle(12);
        wr_reg(3'd3, 32'h0);
        idle(5);
        wr_reg(3'd3, 32'h1);
        idle(23);
        rd_reg(3'd0);
        check("t5_not_yet", last_rd, 32'h0);
        rd_reg(3'd0);
        check("t5_fire", last_rd, 32'h1);

        // Overrun: period 0 left pending across a second fire.
        apply_reset();
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd3, 32'h1);
        idle(9);
        rd_reg(3'd6);
        check("t6_overrun", last_rd, OVR_EXP);
        wr_reg(3'd6, 32'h1);
        rd_reg(3'd6);
        check("t6_overrun_w1c", last_rd, 32'h0);

        // Reset in the middle of a count aborts cleanly and counting restarts from 0.
        apply_reset();
        wr_reg(3'd2, 32'd3);
        wr_reg(3'd3, 32'h1);
        idle(10);
        apply_reset();
        idle(8);
        rd_reg(3'd5);
        check("t7_ticks_cleared", last_rd, 32'h0);
        rd_reg(3'd0);
        check("t7_pend_cleared", last_rd, 32'h0);

        // Random traffic against the model.
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [2:0]  a;
            logic [31:0] d;
            if (n == 1500) apply_reset();
            r = $urandom_range(0, 9);
            a = 3'($urandom_range(0, 7));
            case (a)
                3'd1:    d = 32'($urandom_range(0, 7));
                3'd2:    d = 32'($urandom_range(0, 6));
                3'd3:    d = 32'($urandom_range(0, 15));
                default: d = $urandom();
            endcase
            if (r < 4)      idle(1);
            else if (r < 7) rd_reg(a);
            else            wr_reg(a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
